// File: rtl/hbram_cal_mst_mc_pkg.sv
// Shared types and helpers for the multi-channel HyperRAM read-delay calibration master.
package hbram_cal_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_INIT,
    ST_RST_SLV,
    ST_SETTLE,
    ST_RUN,
    ST_RECORD,
    ST_CENTER,
    ST_APPLY,
    ST_DONE
  } cal_state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned code_max(input int unsigned dly_w);
    return (1 << dly_w) - 1;
  endfunction

endpackage

// File: rtl/hbram_cal_mst_mc_if.sv
// Master <-> calibration-slave control bundle, one bit per channel.
interface hbram_cal_mst_mc_if #(
  parameter int unsigned NUM_CH = 2
) ();
  logic [NUM_CH-1:0] cal_rstn;
  logic [NUM_CH-1:0] cal_en;
  logic [NUM_CH-1:0] cal_done;
  logic [NUM_CH-1:0] cal_fail;

  modport master (output cal_rstn, output cal_en, input cal_done, input cal_fail);
  modport slave  (input cal_rstn, input cal_en, output cal_done, output cal_fail);
endinterface

// File: rtl/hbram_cal_mst_mc_win.sv
// Longest contiguous passing-window tracker; earliest window wins ties, no wrap-around.
module hbram_cal_win #(
  parameter int unsigned DLY_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             rec,
  input  logic             pass,
  input  logic [DLY_W-1:0] code,
  output logic [DLY_W:0]   best_len,
  output logic [DLY_W-1:0] centre
);
  logic [DLY_W-1:0] run_start;
  logic [DLY_W:0]   run_len;
  logic [DLY_W-1:0] best_start;
  logic [DLY_W-1:0] nx_start;
  logic [DLY_W:0]   nx_len;

  always_comb begin
    nx_start = (run_len == '0) ? code : run_start;
    nx_len   = run_len + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (clr) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (rec) begin
      if (pass) begin
        run_start <= nx_start;
        run_len   <= nx_len;
        if (nx_len > best_len) begin
          best_start <= nx_start;
          best_len   <= nx_len;
        end
      end else begin
        run_len <= '0;
      end
    end
  end

  // Floor centre of the best window; meaningless while best_len is zero.
  assign centre = best_start + DLY_W'((best_len - 1'b1) >> 1);

endmodule

// File: rtl/hbram_cal_mst_mc.sv
// Sequential per-channel read-delay sweep; programs the centre of the longest passing window.
module hbram_cal_mst_mc
  import hbram_cal_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DLY_W       = 3,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned RST_CYC     = 4,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init_rdy,
  input  logic                    cal_start,
  hbram_cal_mst_mc_if.master      cal,
  output logic [NUM_CH*DLY_W-1:0] rdav_dly,
  output logic [NUM_CH-1:0]       ch_fail,
  output logic                    mst_cal_done,
  output logic                    mst_cal_fail
);
  localparam int unsigned CH_W     = clog2(NUM_CH);
  localparam int unsigned RTY_W    = clog2(MAX_RETRY + 1);
  localparam int unsigned TMO_W    = clog2(TIMEOUT_CYC + 1);
  localparam int unsigned DCNT_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int unsigned DCNT_W   = clog2(DCNT_MAX + 1);
  localparam logic [DLY_W-1:0] CODE_MAX = DLY_W'(code_max(DLY_W));
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  cal_state_e state, state_nx;

  logic [CH_W-1:0]                 ch;
  logic [DLY_W-1:0]                code;
  logic [RTY_W-1:0]                retry;
  logic [DCNT_W-1:0]               dly_cnt;
  logic [TMO_W-1:0]                tmo_cnt;
  logic                            res_pass;
  logic [NUM_CH-1:0][DLY_W-1:0]    dly_q;

  logic                            win_clr;
  logic                            win_rec;
  logic                            run_end;
  logic                            run_pass;
  logic [DLY_W:0]                  win_len;
  logic [DLY_W-1:0]                win_centre;

  hbram_cal_win #(.DLY_W(DLY_W)) u_win (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (win_clr),
    .rec      (win_rec),
    .pass     (res_pass),
    .code     (code),
    .best_len (win_len),
    .centre   (win_centre)
  );

  always_comb begin
    state_nx     = state;
    cal.cal_rstn = '0;
    cal.cal_en   = '0;
    win_clr      = 1'b0;
    win_rec      = 1'b0;
    run_end      = 1'b0;
    run_pass     = 1'b0;
    case (state)
      ST_WAIT_INIT: begin
        win_clr = 1'b1;
        if (init_rdy) state_nx = ST_RST_SLV;
      end
      ST_RST_SLV: begin
        if (dly_cnt == DCNT_W'(RST_CYC - 1)) state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        cal.cal_rstn[ch] = 1'b1;
        if (dly_cnt == DCNT_W'(SETTLE_CYC - 1)) state_nx = ST_RUN;
      end
      ST_RUN: begin
        cal.cal_rstn[ch] = 1'b1;
        cal.cal_en[ch]   = 1'b1;
        // Fail and timeout take priority over done, so done&fail counts as a fail.
        if (cal.cal_fail[ch] || tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
          run_end = 1'b1;
        end else if (cal.cal_done[ch]) begin
          run_end  = 1'b1;
          run_pass = 1'b1;
        end
        if (run_end) state_nx = ST_RECORD;
      end
      ST_RECORD: begin
        cal.cal_rstn[ch] = 1'b1;
        win_rec          = 1'b1;
        state_nx         = (code == CODE_MAX) ? ST_CENTER : ST_RST_SLV;
      end
      ST_CENTER: begin
        if (win_len == '0 && retry < RTY_W'(MAX_RETRY)) begin
          win_clr  = 1'b1;
          state_nx = ST_RST_SLV;
        end else begin
          state_nx = ST_APPLY;
        end
      end
      ST_APPLY: begin
        cal.cal_rstn[ch] = 1'b1;
        win_clr          = 1'b1;
        state_nx         = (ch == CH_LAST) ? ST_DONE : ST_RST_SLV;
      end
      ST_DONE: begin
        cal.cal_rstn = '1;
        if (cal_start) state_nx = ST_WAIT_INIT;
      end
      default: state_nx = ST_WAIT_INIT;
    endcase
    if (!init_rdy && state != ST_WAIT_INIT) state_nx = ST_WAIT_INIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_WAIT_INIT;
      ch       <= '0;
      code     <= '0;
      retry    <= '0;
      dly_cnt  <= '0;
      tmo_cnt  <= '0;
      res_pass <= 1'b0;
      dly_q    <= '0;
      ch_fail  <= '0;
    end else begin
      state <= state_nx;

      if (state_nx != state)                         dly_cnt <= '0;
      else if (state == ST_RST_SLV || state == ST_SETTLE) dly_cnt <= dly_cnt + 1'b1;

      if (state_nx != state)    tmo_cnt <= '0;
      else if (state == ST_RUN) tmo_cnt <= tmo_cnt + 1'b1;

      // Any return to WAIT_INIT (abort or rerun request) wipes progress and status.
      if (state_nx == ST_WAIT_INIT) begin
        ch      <= '0;
        code    <= '0;
        retry   <= '0;
        dly_q   <= '0;
        ch_fail <= '0;
      end else begin
        case (state)
          ST_RST_SLV: dly_q[ch] <= code;
          ST_RUN:     res_pass  <= run_pass;
          ST_RECORD:  if (code != CODE_MAX) code <= code + 1'b1;
          ST_CENTER: begin
            if (win_len == '0) begin
              if (retry < RTY_W'(MAX_RETRY)) begin
                retry <= retry + 1'b1;
                code  <= '0;
              end else begin
                ch_fail[ch] <= 1'b1;
                dly_q[ch]   <= '0;
              end
            end else begin
              dly_q[ch] <= win_centre;
            end
          end
          ST_APPLY: begin
            if (ch != CH_LAST) begin
              ch    <= ch + 1'b1;
              retry <= '0;
              code  <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rdav_dly     = dly_q;
  assign mst_cal_done = (state == ST_DONE);
  assign mst_cal_fail = mst_cal_done & (|ch_fail);

endmodule

// File: tb/tb_hbram_cal_mst_mc.sv
// Directed bench for hbram_cal_mst_mc with a per-channel pass/fail/silent slave model.
module tb_hbram_cal_mst_mc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_rdy = 1'b0;
  logic       cal_start = 1'b0;
  logic [5:0] rdav_dly;
  logic [1:0] ch_fail;
  logic       mst_cal_done;
  logic       mst_cal_fail;

  hbram_cal_mst_mc_if #(.NUM_CH(2)) cal_if ();

  hbram_cal_mst_mc #(
    .NUM_CH      (2),
    .DLY_W       (3),
    .MAX_RETRY   (2),
    .RST_CYC     (4),
    .SETTLE_CYC  (16),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_rdy     (init_rdy),
    .cal_start    (cal_start),
    .cal          (cal_if),
    .rdav_dly     (rdav_dly),
    .ch_fail      (ch_fail),
    .mst_cal_done (mst_cal_done),
    .mst_cal_fail (mst_cal_fail)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  pass_m   [2] = '{8'h00, 8'h00};
  logic [7:0]  silent_m [2] = '{8'h00, 8'h00};
  logic [7:0]  both_m   [2] = '{8'h00, 8'h00};
  int unsigned pulses   [2] = '{0, 0};
  int unsigned hi       [2] = '{0, 0};
  int unsigned hi_len   [2][8] = '{default: 0};
  logic [2:0]  last_code [2] = '{3'd0, 3'd0};
  logic        en_q     [2] = '{1'b0, 1'b0};
  int unsigned viol = 0;

  // Slave model: answers on the 3rd cycle of cal_en according to the masks.
  always @(negedge clk) begin
    if (!mst_cal_done && ($countones(cal_if.cal_rstn) > 1 || $countones(cal_if.cal_en) > 1))
      viol = viol + 1;
    for (int c = 0; c < 2; c++) begin
      logic [2:0] code;
      code = rdav_dly[c*3 +: 3];
      if (cal_if.cal_en[c] === 1'b1) begin
        if (!en_q[c]) begin
          pulses[c] = pulses[c] + 1;
          hi[c] = 0;
        end
        hi[c] = hi[c] + 1;
        last_code[c] = code;
        if (hi[c] >= 3 && !silent_m[c][code]) begin
          cal_if.cal_done[c] = pass_m[c][code] | both_m[c][code];
          cal_if.cal_fail[c] = ~pass_m[c][code] | both_m[c][code];
        end else begin
          cal_if.cal_done[c] = 1'b0;
          cal_if.cal_fail[c] = 1'b0;
        end
        en_q[c] = 1'b1;
      end else begin
        if (en_q[c]) hi_len[c][last_code[c]] = hi[c];
        cal_if.cal_done[c] = 1'b0;
        cal_if.cal_fail[c] = 1'b0;
        en_q[c] = 1'b0;
      end
    end
  end

  task automatic wait_done(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (mst_cal_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_en(input logic [1:0] m, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if ((cal_if.cal_en & m) != 2'b00) ok = 1'b1;
    end
  endtask

  task automatic restart();
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] outs;
    rst_n = 1'b0;
    init_rdy = 1'b0;
    repeat (3) @(negedge clk);
    outs = {cal_if.cal_rstn, cal_if.cal_en, rdav_dly, ch_fail, mst_cal_done, mst_cal_fail};
    checks++;
    if (outs !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", outs, 12'h000);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    outs = {cal_if.cal_rstn, cal_if.cal_en, rdav_dly, ch_fail, mst_cal_done, mst_cal_fail};
    checks++;
    if (outs !== 12'h000) begin
      errors++;
      $display("FAIL idle_no_init: got %b expected %b", outs, 12'h000);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int unsigned p0, p1, v0;
    pass_m[0] = 8'h3C;
    pass_m[1] = 8'hF6;
    p0 = pulses[0];
    p1 = pulses[1];
    v0 = viol;
    init_rdy = 1'b1;
    wait_done(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done: got timeout expected mst_cal_done=1"); end
    checks++;
    if (rdav_dly !== 6'b101_011) begin errors++; $display("FAIL basic_dly: got %b expected %b", rdav_dly, 6'b101_011); end
    checks++;
    if ({ch_fail, mst_cal_fail} !== 3'b000) begin errors++; $display("FAIL basic_status: got %b expected %b", {ch_fail, mst_cal_fail}, 3'b000); end
    checks++;
    if ({cal_if.cal_rstn, cal_if.cal_en} !== 4'b1100) begin errors++; $display("FAIL done_ctrl: got %b expected %b", {cal_if.cal_rstn, cal_if.cal_en}, 4'b1100); end
    checks++;
    if (pulses[0] - p0 != 8 || pulses[1] - p1 != 8) begin
      errors++;
      $display("FAIL basic_pulses: got %0d/%0d expected 8/8", pulses[0] - p0, pulses[1] - p1);
    end
    checks++;
    if (viol != v0) begin errors++; $display("FAIL single_active: got %0d expected %0d", viol, v0); end
  endtask

  task automatic test_edges();
    bit ok;
    pass_m[0] = 8'h80;
    pass_m[1] = 8'hFF;
    restart();
    checks++;
    if (mst_cal_done !== 1'b0) begin errors++; $display("FAIL restart_drop: got %b expected 0", mst_cal_done); end
    wait_done(3000, ok);
    checks++;
    if (!ok || rdav_dly !== 6'b011_111) begin errors++; $display("FAIL edge_top_full: got %b expected %b", rdav_dly, 6'b011_111); end
    pass_m[0] = 8'hFF;
    pass_m[1] = 8'h80;
    restart();
    wait_done(3000, ok);
    checks++;
    if (!ok || rdav_dly !== 6'b111_011) begin errors++; $display("FAIL edge_full_top: got %b expected %b", rdav_dly, 6'b111_011); end
  endtask

  task automatic test_retry();
    bit ok;
    int unsigned p0, p1;
    pass_m[0] = 8'h0F;
    pass_m[1] = 8'h00;
    p0 = pulses[0];
    p1 = pulses[1];
    restart();
    wait_done(4000, ok);
    checks++;
    if (!ok || {ch_fail, mst_cal_fail} !== 3'b101) begin errors++; $display("FAIL retry_status: got %b expected %b", {ch_fail, mst_cal_fail}, 3'b101); end
    checks++;
    if (rdav_dly !== 6'b000_001) begin errors++; $display("FAIL retry_dly: got %b expected %b", rdav_dly, 6'b000_001); end
    checks++;
    if (pulses[0] - p0 != 8 || pulses[1] - p1 != 24) begin
      errors++;
      $display("FAIL retry_pulses: got %0d/%0d expected 8/24", pulses[0] - p0, pulses[1] - p1);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    pass_m[0] = 8'h6F;
    silent_m[0] = 8'h10;
    pass_m[1] = 8'hFF;
    restart();
    wait_done(3000, ok);
    checks++;
    if (!ok || rdav_dly !== 6'b011_001) begin errors++; $display("FAIL timeout_dly: got %b expected %b", rdav_dly, 6'b011_001); end
    checks++;
    if (hi_len[0][4] != 64 || hi_len[0][3] != 3) begin
      errors++;
      $display("FAIL timeout_len: got %0d/%0d expected 64/3", hi_len[0][4], hi_len[0][3]);
    end
    both_m[0] = 8'h04;
    restart();
    wait_done(3000, ok);
    checks++;
    if (!ok || rdav_dly !== 6'b011_000) begin errors++; $display("FAIL both_tie_dly: got %b expected %b", rdav_dly, 6'b011_000); end
    checks++;
    if (mst_cal_fail !== 1'b0) begin errors++; $display("FAIL both_status: got %b expected 0", mst_cal_fail); end
    silent_m[0] = 8'h00;
    both_m[0] = 8'h00;
  endtask

  task automatic test_abort();
    bit ok;
    logic [11:0] outs;
    pass_m[0] = 8'h3C;
    pass_m[1] = 8'hF6;
    restart();
    wait_en(2'b10, 2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_reach_ch1: got timeout expected cal_en[1]=1"); end
    init_rdy = 1'b0;
    @(posedge clk);
    #1;
    outs = {cal_if.cal_rstn, cal_if.cal_en, rdav_dly, ch_fail, mst_cal_done, mst_cal_fail};
    checks++;
    if (outs !== 12'h000) begin errors++; $display("FAIL abort_outputs: got %b expected %b", outs, 12'h000); end
    @(negedge clk);
    init_rdy = 1'b1;
    wait_en(2'b11, 200, ok);
    checks++;
    if (!ok || cal_if.cal_en !== 2'b01 || rdav_dly !== 6'b000_000) begin
      errors++;
      $display("FAIL abort_restart: got en=%b dly=%b expected en=01 dly=000000", cal_if.cal_en, rdav_dly);
    end
    wait_done(3000, ok);
    checks++;
    if (!ok || rdav_dly !== 6'b101_011) begin errors++; $display("FAIL abort_final: got %b expected %b", rdav_dly, 6'b101_011); end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int unsigned p0, p1;
    p0 = pulses[0];
    p1 = pulses[1];
    restart();
    wait_en(2'b01, 200, ok);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    checks++;
    if (!ok || cal_if.cal_en !== 2'b01 || mst_cal_done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run: got en=%b done=%b expected en=01 done=0", cal_if.cal_en, mst_cal_done);
    end
    wait_done(3000, ok);
    checks++;
    if (!ok || rdav_dly !== 6'b101_011 || pulses[0] - p0 != 8 || pulses[1] - p1 != 8) begin
      errors++;
      $display("FAIL start_ignored: got dly=%b pulses=%0d/%0d expected dly=101011 pulses=8/8",
               rdav_dly, pulses[0] - p0, pulses[1] - p1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_retry();
    test_timeout();
    test_abort();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hbram_cal_mst_mc.md
Name: hbram_cal_mst_mc

Overview:
Multi-channel, parametrised HyperRAM read-delay calibration coordinator. After controller init it sweeps every read-data-valid delay code per channel, running the per-channel calibration slave at each code. It locates the longest contiguous passing window and programs its centre code. Sits between hbram controller init logic and NUM_CH calibration slaves; replaces the single-channel increment-only master.

Parameters:
NUM_CH, 2, number of HyperRAM channels / calibration slaves
DLY_W, 3, delay code width; codes 0..2**DLY_W-1
MAX_RETRY, 2, full-sweep retries per channel after first sweep finds no passing code
RST_CYC, 4, cycles slave reset held low before each code
SETTLE_CYC, 16, cycles after delay code change before cal_en asserted
TIMEOUT_CYC, 4096, max cycles waiting for slave done/fail; expiry = fail

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
init_rdy  in  1  controller init complete (level)
cal_start  in  1  pulse: rerun full calibration when idle/finished
cal_rstn  out  NUM_CH  per-slave active-low reset
cal_en  out  NUM_CH  per-slave calibration enable
cal_done  in  NUM_CH  slave pass indication (level, valid while cal_en)
cal_fail  in  NUM_CH  slave fail indication (level, valid while cal_en)
rdav_dly  out  NUM_CH*DLY_W  per-channel delay code, ch0 in LSBs
ch_fail  out  NUM_CH  channel had no passing code after all retries
mst_cal_done  out  1  calibration sequence finished (pass or fail)
mst_cal_fail  out  1  OR of ch_fail, valid when mst_cal_done

Behaviour:
- One clock, clk; reset rst_n asynchronous, active-low. Reset values: cal_rstn=0, cal_en=0, rdav_dly=0, ch_fail=0, mst_cal_done=0, mst_cal_fail=0, FSM=WAIT_INIT.
- Channels calibrated sequentially, ch 0 first; only active channel's cal_rstn/cal_en toggle, others keep cal_rstn=0, cal_en=0 during calibration.
- FSM states:
  WAIT_INIT: wait for init_rdy=1; clear ch index, retry count, window regs -> RST_SLV.
  RST_SLV: cal_rstn[ch]=0 for RST_CYC cycles, rdav_dly[ch]=code -> SETTLE.
  SETTLE: cal_rstn[ch]=1, wait SETTLE_CYC -> RUN.
  RUN: cal_en[ch]=1; on cal_fail or timeout record fail; else on cal_done record pass -> RECORD. cal_done and cal_fail high together = fail.
  RECORD (1 cycle): cal_en=0; update window tracker; if code==max -> CENTER, else code+1 -> RST_SLV.
  CENTER: best_len==0: retry<MAX_RETRY -> retry+1, code=0, RST_SLV; else ch_fail[ch]=1, rdav_dly[ch]=0. Otherwise rdav_dly[ch]=best_start+((best_len-1)>>1) (floor centre) -> APPLY.
  APPLY: cal_rstn[ch]=1 with final code; ch<NUM_CH-1 -> ch+1, reset retry/window, RST_SLV; else DONE.
  DONE: mst_cal_done=1, mst_cal_fail=|ch_fail; all cal_rstn=1, cal_en=0; final codes held. cal_start -> clear status, WAIT_INIT.
- Window tracker: run_start/run_len (DLY_W+1 bits), best_start/best_len. On pass run_len+1 (run_start=code if run_len==0); on fail run_len=0. best updated when run_len > best_len (strict: earliest window wins ties). Wrap-around not considered: code max and code 0 are not adjacent.
- Timeout counter clog2(TIMEOUT_CYC+1) bits, cleared on RUN entry.
- init_rdy falling in any state except WAIT_INIT: abort to WAIT_INIT, all outputs to reset values.
- cal_start ignored unless in DONE.
- Per-code latency = RST_CYC + SETTLE_CYC + slave time + 1 cycle.

Decomposition:
- Package hbram_cal_pkg: FSM state encoding, clog2 helper function, code max constant.
- Sub-module hbram_cal_win: window tracker (inputs clr, rec, pass, code; outputs best_start, best_len, centre code); single instance shared across channels.

Test Plan:
- NUM_CH=2, DLY_W=3; ch0 passes codes 2..5, ch1 passes 1,2,4..7 -> rdav_dly = {3'd5, 3'd3}, mst_cal_done=1, mst_cal_fail=0, ch_fail=2'b00.
- ch0 passes only code 7 -> rdav_dly[2:0]=7; ch0 passes codes 0..7 -> centre 3.
- ch1 never passes, MAX_RETRY=2 -> exactly 3 sweeps (24 cal_en pulses) on ch1, ch_fail=2'b10, mst_cal_fail=1, rdav_dly[5:3]=0.
- Slave silent at code 4, TIMEOUT_CYC=64 -> cal_en drops after 64 cycles, code 4 fail; ch0 passes 0..3 and 5..6 -> centre 1; cal_done&cal_fail together at code 2 -> treated as fail, window recomputed accordingly.
- init_rdy dropped mid-sweep on ch1 -> next cycle all outputs at reset values; init_rdy reasserted -> restart from ch0 code 0.
- After DONE, cal_start pulse -> mst_cal_done drops, full recalibration repeats; cal_start pulse during RUN -> no effect.
